// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared constants and FSM encoding for reg_share_arb
package reg_share_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_share_arb_if.sv
// rtl/reg_share_arb_if.sv - requester-side request/grant/ack bundle
interface reg_share_arb_if
  import reg_share_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;

  modport master (output req, output wdata, input gnt, input ack);
  modport slave  (input req, input wdata, output gnt, output ack);

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick starting just after last
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] win,
  output logic            valid
);

  always_comb begin
    int              k;
    logic [IDXW-1:0] kk;
    win   = '0;
    valid = 1'b0;
    k     = 0;
    kk    = '0;
    // offsets 1..N so that last itself is considered only after everyone else
    for (int i = 1; i <= N; i++) begin
      k  = (int'(last) + i) % N;
      kk = IDXW'(k);
      if (!valid && req[kk]) begin
        valid = 1'b1;
        win   = kk;
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin sharing of one register among N writers
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_share_arb_if.slave   bus,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  owner,
  output logic             busy
);

  state_t          state;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] wsel;
  logic [IDXW-1:0] pick_win;
  logic            pick_valid;
  logic [N-1:0]    pick_onehot;
  logic [WIDTH-1:0] lane [N];

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req   (bus.req),
    .last  (last),
    .win   (pick_win),
    .valid (pick_valid)
  );

  assign pick_onehot = N'(1) << pick_win;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last    <= IDXW'(N-1);
      wsel    <= '0;
      bus.gnt <= '0;
      bus.ack <= '0;
      q       <= '0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            wsel    <= pick_win;
            bus.gnt <= pick_onehot;
            busy    <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // clr on this edge overrides the committed data but not the bookkeeping
          q       <= clr ? '0 : lane[wsel];
          owner   <= wsel;
          last    <= wsel;
          bus.ack <= bus.gnt;
          bus.gnt <= '0;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          bus.ack <= '0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          bus.gnt <= '0;
          bus.ack <= '0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
      if (clr && state != ST_GRANT) begin
        q <= '0;
      end
    end
  end

endmodule

// File: doc/reg_share_arb.md
Name: reg_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit storage register (a bank of asynchronously reset D flip-flops) among N requesters.
- Each requester raises req with its write data. The block grants one requester at a time, commits that requester's data into the register, and returns a one-cycle ack.
- Sits between requester logic and the shared flip-flop register; the register is held inside the block.

Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 8, data width of the shared register
- IDXW, $clog2(N), width of requester index

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester write request; level, held until ack
- wdata  input  N*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of shared register
- gnt  output  N  one-hot grant, registered
- ack  output  N  one-hot write-complete pulse, registered
- q  output  WIDTH  shared register contents
- owner  output  IDXW  index of last requester that wrote q
- busy  output  1  high while FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. rst_n low at any time, including mid-transaction, immediately forces:
  - q=0, gnt=0, ack=0, busy=0, owner=0
  - FSM=IDLE, round-robin pointer last=N-1, so requester 0 has top priority after reset
  - No partial write survives reset.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req != 0, select the winner w as the first set bit scanning last+1, last+2, … modulo N.
  - Next edge: gnt <= onehot(w), latch w internally, FSM -> GRANT, busy -> 1.
  - If req == 0, remain in IDLE with gnt=0.
- GRANT (exactly 1 cycle):
  - At the edge leaving GRANT: q <= wdata[w], owner <= w, last <= w, gnt <= 0, ack <= onehot(w), FSM -> ACK.
  - The write commits even if req[w] dropped during GRANT.
  - wdata is sampled only at that edge.
- ACK (exactly 1 cycle):
  - ack asserted. Next edge: ack <= 0, FSM -> IDLE.
  - The requester must drop req on the cycle after it sees ack. A req still high in IDLE is treated as a new request.
- Latency: a req sampled high in IDLE gives gnt at +1 cycle, q updated and ack at +2, and the FSM is back in IDLE at +3.
  - Minimum transaction period is 3 cycles.
  - Back-to-back requests from different requesters alternate by round-robin.
- Fairness: with all N requesting continuously, grants cycle w = 0,1,…,N-1,0,… with no requester starved longer than N transactions.
- Pointer wrap: last=N-1 wraps to a scan starting at 0.
- clr:
  - Synchronous. At an edge with clr=1, q <= 0. owner is unchanged.
  - If clr coincides with the GRANT->ACK edge, clr wins: q=0, but ack is still issued and last/owner still update.
  - clr does not affect FSM, gnt or ack.
- Invariants:
  - gnt and ack are each one-hot or zero.
  - gnt and ack are never high in the same cycle.
  - At most one of gnt/ack is non-zero at any time.
- No X propagation: unused wdata lanes are ignored.

Decomposition:
- Shared package reg_share_pkg:
  - FSM state encoding (IDLE=2'd0, GRANT=2'd1, ACK=2'd2)
  - Default N/WIDTH constants
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs req[N] and last[IDXW]; outputs the winner index and a valid flag.
  - Isolates the rotating priority scan for separate unit test.
- The FSM, register, clr and owner logic stay in reg_share_arb.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> q=8'h00, gnt=0, ack=0, busy=0; release -> first gnt=4'b0001.
- Single request: req=4'b0100 with wdata lane2=8'hA5 -> gnt=4'b0100 at +1, q=8'hA5, owner=2, ack=4'b0100 at +2, busy low at +3.
- Round robin: req=4'b1111 held (each lane = 8'h10+i), re-asserted after each ack -> grant order 0,1,2,3,0; q sequence 10,11,12,13,10.
- Contention after wrap: last=3, req=4'b1010 -> gnt=4'b0010; next transaction -> gnt=4'b1000.
- clr collision: clr=1 on the GRANT->ACK edge with wdata lane1=8'h3C -> q=8'h00, ack=4'b0010, owner=1.
- Reset mid-op: drop rst_n during GRANT -> gnt clears asynchronously, q=0, no ack ever issued, FSM=IDLE after release.
